div_ctrl: RTL
=============

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the divide and duty counters.
REQ-002 SHALL have parameter DEF_DIV, default 16, active period length after reset.
REQ-003 SHALL have parameter DEF_DUTY, default 4, active high-time after reset.
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports start and stop  input  1 each  run and stop requests, sampled per cycle.
REQ-007 SHALL have ports cfg_valid  input  1, and cfg_ready  output  1  config handshake.
REQ-008 SHALL have ports cfg_div and cfg_duty  input  CNT_W each  requested period and high-time.
REQ-009 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected config.
REQ-010 SHALL have port clk_div  output  1  registered divided output.
REQ-011 SHALL have port tick  output  1  one-cycle pulse at each period start.
REQ-012 SHALL have port busy  output  1  high in RUN or STOPPING.

Function
REQ-013 SHALL implement states IDLE, RUN and STOPPING.
REQ-014 IDLE: start=1 and stop=0 SHALL move to RUN on the next edge, with cnt=0.
REQ-015 RUN: stop=1 SHALL move to STOPPING, and start SHALL be ignored that cycle.
REQ-016 STOPPING: start=1 SHALL return to RUN with no break in the count.
REQ-017 STOPPING: at cnt==div-1 without start, SHALL move to IDLE and clear cnt and clk_div.
REQ-018 In RUN and STOPPING, cnt SHALL increment each cycle and wrap to 0 after div-1.
REQ-019 In RUN and STOPPING, clk_div SHALL be registered as (cnt < duty), giving one cycle of latency from cnt.
REQ-020 tick SHALL pulse on the cycle after the register sees cnt==0 in RUN or STOPPING.
REQ-021 In IDLE, clk_div, tick and cnt SHALL be 0.
REQ-022 A config SHALL be accepted on the cycle where cfg_valid and cfg_ready are both 1.
REQ-023 A config SHALL be valid only when cfg_div>=2 and cfg_duty<=cfg_div.
REQ-024 An invalid config SHALL be discarded, pulse cfg_err on the next cycle, and leave cfg_ready at 1.
REQ-025 A valid config accepted in IDLE SHALL load the active div/duty on the next edge.
REQ-026 A valid config accepted in RUN or STOPPING SHALL be held as pending, and cfg_ready SHALL be 0 while it is pending.
REQ-027 A pending config SHALL load on the edge where cnt wraps from div-1 to 0, and cfg_ready SHALL rise on the next cycle.
REQ-028 If IDLE is entered with a config still pending, that config SHALL load on entry.
REQ-029 duty==0 SHALL hold clk_div at 0, and duty==div SHALL hold clk_div at 1, throughout RUN.
REQ-030 All comparisons SHALL be unsigned CNT_W-bit with no overflow, since cnt is always < div.

Reset
REQ-031 rst=1 SHALL force IDLE with cnt=0, clk_div=0, tick=0, busy=0 and cfg_err=0.
REQ-032 rst=1 SHALL force cfg_ready=1, clear any pending config, and set the active div/duty to DEF_DIV/DEF_DUTY.
REQ-033 Reset asserted mid-period SHALL take effect immediately, with no completion of the period.

Configuration
REQ-034 Macro DIV_CTRL_PERIOD_CNT_EN, when defined, SHALL add output period_cnt (16 bits).
REQ-035 With the macro defined, period_cnt SHALL increment on each tick, saturate at 0xFFFF, and clear on reset or on IDLE->RUN.
REQ-036 Without the macro, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 Package div_ctrl_pkg SHALL hold the state enum (IDLE, RUN, STOPPING) and a config struct {div, duty}.
REQ-038 Sub-module div_ctrl_cfg SHALL contain the validation, the pending register and cfg_ready/cfg_err.
REQ-039 The top level SHALL contain the FSM, the counter and the outputs.

Verification
REQ-040 Reset, then start for one cycle with defaults -> clk_div high 4 cycles, low 12, period 16; tick every 16 cycles.
REQ-041 In IDLE, cfg div=5, duty=2 accepted, then start -> clk_div pattern 11000 repeating; busy=1.
REQ-042 In RUN at div=16, cfg div=8, duty=8 at cnt=3 -> cfg_ready=0 until the wrap; the next period is 8 cycles with clk_div held at 1.
REQ-043 cfg div=1 or duty=9 with div=8 -> cfg_err pulses one cycle; active config unchanged; cfg_ready stays 1.
REQ-044 stop at cnt=5 with div=16 -> busy stays 1 until cnt=15, then IDLE with clk_div=0; start during STOPPING -> count continues.
REQ-045 rst asserted at cnt=7 with a pending config -> outputs reset at once; after restart the period is 16 (pending config discarded).

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared types for the div_ctrl clock divider: FSM state encoding and the
// {div, duty} configuration record exchanged between the top and div_ctrl_cfg.
package div_ctrl_pkg;

  // Config fields are stored at this fixed width; CNT_W must not exceed it.
  localparam int CNT_W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] div;
    logic [CNT_W_MAX-1:0] duty;
  } cfg_t;

  function automatic logic cfg_is_valid(input cfg_t c);
    return (c.div >= CNT_W_MAX'(2)) && (c.duty <= c.div);
  endfunction

endpackage

// File: rtl/div_ctrl_cfg.sv
// Configuration front end for div_ctrl: validates requests, applies them at
// once in IDLE or parks them in a pending register until the period wraps.
module div_ctrl_cfg
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 16,
  parameter int DEF_DUTY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  input  logic [CNT_W-1:0] cfg_duty_i,
  input  logic             idle_i,
  input  logic             wrap_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output cfg_t             act_o
);

  // Handshake: a request transfers on any cycle with cfg_valid_i && cfg_ready_o;
  // cfg_ready_o never depends on cfg_valid_i, and drops only while a pending
  // config waits for the end of the current period.
  cfg_t req;
  cfg_t act_q, act_d;
  cfg_t pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic accept;
  logic req_ok;

  always_comb begin
    req = '0;
    req.div[CNT_W-1:0]  = cfg_div_i;
    req.duty[CNT_W-1:0] = cfg_duty_i;
  end

  assign accept = cfg_valid_i && ready_q;
  assign req_ok = cfg_is_valid(req);

  always_comb begin
    act_d    = act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    ready_d  = ready_q;
    err_d    = accept && !req_ok;
    if (pend_v_q && wrap_i) begin
      act_d    = pend_q;
      pend_v_d = 1'b0;
      ready_d  = 1'b1;
    end
    if (accept && req_ok) begin
      if (idle_i) begin
        act_d = req;
      end else begin
        pend_d   = req;
        pend_v_d = 1'b1;
        ready_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q    <= '{div: CNT_W_MAX'(DEF_DIV), duty: CNT_W_MAX'(DEF_DUTY)};
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = err_q;
  assign act_o       = act_q;

endmodule

// File: rtl/div_ctrl.sv
// Programmable clock divider with run/stop control and registered outputs.
// Optional macro DIV_CTRL_PERIOD_CNT_EN adds a saturating 16-bit period counter.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 16,
  parameter int DEF_DUTY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
`ifdef DIV_CTRL_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output state_e           dbg_state
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 clk_div_q, clk_div_d;
  logic                 tick_q, tick_d;
  logic [CNT_W_MAX-1:0] cnt_ext;
  logic                 active;
  logic                 at_end;
  cfg_t                 act;

  div_ctrl_cfg #(
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV),
    .DEF_DUTY(DEF_DUTY)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid_i(cfg_valid),
    .cfg_div_i  (cfg_div),
    .cfg_duty_i (cfg_duty),
    .idle_i     (state_q == IDLE),
    .wrap_i     (at_end),
    .cfg_ready_o(cfg_ready),
    .cfg_err_o  (cfg_err),
    .act_o      (act)
  );

  assign cnt_ext = CNT_W_MAX'(cnt_q);
  assign active  = (state_q != IDLE);
  // Every exit from the last count (wrap, stop-to-idle) returns cnt to 0.
  assign at_end  = active && (cnt_ext == act.div - CNT_W_MAX'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = at_end ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) state_d = STOPPING;
      end
      STOPPING: begin
        if (start)       state_d = RUN;
        else if (at_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    clk_div_d = active && (state_d != IDLE) && (cnt_ext < act.duty);
    tick_d    = active && (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_div   = clk_div_q;
  assign tick      = tick_q;
  assign busy      = active;
  assign dbg_state = state_q;

`ifdef DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] pcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == RUN)) begin
      pcnt_q <= '0;
    end else if (tick_q && (pcnt_q != 16'hFFFF)) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign period_cnt = pcnt_q;
`endif

endmodule
